acc_supervisor: RTL and testbench

Driver-facing supervisor that configures and sequences the adaptive-cruise/lock control unit. It owns the ACC engagement mode (off/standby/active/brake override), captures and adjusts the driver set speed from buttons, and drives the `speed_limit` seen by the control unit. `speed_limit` is rate-limited upward and zeroed when ACC is not active, which forces the control unit to decelerate. Sits between the driver button/pedal interface and the control unit's `speed_limit` input.

---
 rtl/acc_supervisor_if.sv | 25 ++
 rtl/acc_supervisor.sv | 190 +++++++++++++++++++
 tb/tb_acc_supervisor.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/acc_supervisor_if.sv
// rtl/acc_supervisor_if.sv - driver button/pedal inputs and control-unit outputs of the ACC supervisor
interface acc_supervisor_if;
    logic       acc_on;
    logic       set_btn;
    logic       resume_btn;
    logic       inc_btn;
    logic       dec_btn;
    logic       brake;
    logic [7:0] car_speed;
    logic [7:0] speed_limit;
    logic [7:0] set_speed;
    logic       set_valid;
    logic       acc_active;
    logic [1:0] mode;

    modport master (
        output acc_on, set_btn, resume_btn, inc_btn, dec_btn, brake, car_speed,
        input  speed_limit, set_speed, set_valid, acc_active, mode
    );

    modport slave (
        input  acc_on, set_btn, resume_btn, inc_btn, dec_btn, brake, car_speed,
        output speed_limit, set_speed, set_valid, acc_active, mode
    );
endinterface

// File: rtl/acc_supervisor.sv
// rtl/acc_supervisor.sv - ACC engagement FSM, set-speed buttons and rate-limited speed_limit; ACC_SUP_OVR_TIMEOUT_EN adds override timeout
module acc_supervisor #(
    parameter logic [7:0]  MIN_SET       = 8'd30,
    parameter logic [7:0]  MAX_SPEED     = 8'd120,
    parameter logic [7:0]  STEP          = 8'd2,
    parameter logic [7:0]  RAMP_STEP     = 8'd1,
    parameter logic [15:0] RAMP_CYCLES   = 16'd4,
    parameter logic [15:0] REPEAT_CYCLES = 16'd8,
    parameter logic [15:0] OVR_TIMEOUT   = 16'd1000
) (
    input logic         clk,
    input logic         rstn,
    acc_supervisor_if.slave sup
);

    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_STANDBY  = 2'b01,
        MODE_ACTIVE   = 2'b10,
        MODE_OVERRIDE = 2'b11
    } mode_e;

    mode_e       mode_q, mode_d;
    logic [7:0]  set_speed_q, set_speed_d;
    logic        set_valid_q, set_valid_d;
    logic [7:0]  speed_limit_q, speed_limit_d;
    logic        acc_active_q, acc_active_d;
    logic [15:0] ramp_cnt_q, ramp_cnt_d;
    logic [15:0] rep_cnt_q, rep_cnt_d;
    logic        set_prev_q, resume_prev_q, inc_prev_q, dec_prev_q;

    logic        set_edge, resume_edge, inc_edge, dec_edge;
    logic        in_range;
    logic [8:0]  inc_sum;
    logic [7:0]  inc_sat, dec_sat;
    logic        ramp_tick;
    logic [7:0]  ramp_gap, ramp_amt;

    assign set_edge    = sup.set_btn    & ~set_prev_q;
    assign resume_edge = sup.resume_btn & ~resume_prev_q;
    assign inc_edge    = sup.inc_btn    & ~inc_prev_q;
    assign dec_edge    = sup.dec_btn    & ~dec_prev_q;
    assign in_range    = (sup.car_speed >= MIN_SET) && (sup.car_speed <= MAX_SPEED);

    // Nine-bit sum so an increment near 255 cannot wrap before saturation.
    assign inc_sum = {1'b0, set_speed_q} + {1'b0, STEP};
    assign inc_sat = (inc_sum > {1'b0, MAX_SPEED}) ? MAX_SPEED : inc_sum[7:0];
    assign dec_sat = ({1'b0, set_speed_q} < ({1'b0, MIN_SET} + {1'b0, STEP})) ?
                     MIN_SET : (set_speed_q - STEP);

`ifdef ACC_SUP_OVR_TIMEOUT_EN
    logic [15:0] ovr_cnt_q, ovr_cnt_d;

    // Override dwell counter, running only while OVERRIDE persists.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ovr_cnt_q <= '0;
        else       ovr_cnt_q <= ovr_cnt_d;
    end
`else
    // Keeps OVR_TIMEOUT referenced when the timeout is not built.
    logic unused_ovr_timeout;
    assign unused_ovr_timeout = ^OVR_TIMEOUT;
`endif

    // Mode, set speed, repeat counter and speed_limit ramp next-state.
    always_comb begin
        mode_d        = mode_q;
        set_speed_d   = set_speed_q;
        set_valid_d   = set_valid_q;
        rep_cnt_d     = '0;
        ramp_cnt_d    = '0;
        speed_limit_d = '0;
        ramp_tick     = 1'b0;
        ramp_gap      = '0;
        ramp_amt      = '0;

        if (!sup.acc_on) begin
            mode_d      = MODE_OFF;
            set_speed_d = '0;
            set_valid_d = 1'b0;
        end else begin
            case (mode_q)
                MODE_OFF: mode_d = MODE_STANDBY;
                MODE_STANDBY, MODE_OVERRIDE: begin
                    if (!sup.brake) begin
                        if (set_edge) begin
                            if (in_range) begin
                                mode_d      = MODE_ACTIVE;
                                set_speed_d = sup.car_speed;
                                set_valid_d = 1'b1;
                            end
                        end else if (resume_edge && set_valid_q) begin
                            mode_d = MODE_ACTIVE;
                        end
                    end
                end
                MODE_ACTIVE: begin
                    if (sup.brake) begin
                        mode_d = MODE_OVERRIDE;
                    end else if (set_edge) begin
                        if (in_range) begin
                            set_speed_d = sup.car_speed;
                            set_valid_d = 1'b1;
                        end
                    end else if (!resume_edge && (sup.inc_btn ^ sup.dec_btn)) begin
                        // Edge steps at once; holding steps every REPEAT_CYCLES.
                        if ((sup.inc_btn ? inc_edge : dec_edge) ||
                            (rep_cnt_q == REPEAT_CYCLES - 16'd1)) begin
                            set_speed_d = sup.inc_btn ? inc_sat : dec_sat;
                        end else begin
                            rep_cnt_d = rep_cnt_q + 16'd1;
                        end
                    end
                end
                default: mode_d = MODE_OFF;
            endcase
        end

`ifdef ACC_SUP_OVR_TIMEOUT_EN
        ovr_cnt_d = '0;
        if (mode_q == MODE_OVERRIDE && mode_d == MODE_OVERRIDE) begin
            if (ovr_cnt_q == OVR_TIMEOUT - 16'd1) begin
                mode_d      = MODE_STANDBY;
                set_valid_d = 1'b0;
            end else begin
                ovr_cnt_d = ovr_cnt_q + 16'd1;
            end
        end
`endif

        // speed_limit follows the new set speed: drops at once, rises by ramp ticks.
        if (mode_d == MODE_ACTIVE) begin
            if (mode_q != MODE_ACTIVE) begin
                speed_limit_d = (sup.car_speed < set_speed_d) ? sup.car_speed : set_speed_d;
            end else begin
                speed_limit_d = speed_limit_q;
                if (ramp_cnt_q == RAMP_CYCLES - 16'd1) begin
                    ramp_tick = 1'b1;
                end else begin
                    ramp_cnt_d = ramp_cnt_q + 16'd1;
                end
                ramp_gap = set_speed_d - speed_limit_q;
                ramp_amt = (ramp_gap < RAMP_STEP) ? ramp_gap : RAMP_STEP;
                if (set_speed_d < speed_limit_q) begin
                    speed_limit_d = set_speed_d;
                end else if (ramp_tick && (speed_limit_q < set_speed_d)) begin
                    speed_limit_d = speed_limit_q + ramp_amt;
                end
            end
        end

        acc_active_d = (mode_d == MODE_ACTIVE);
    end

    // State, output and button-history registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q        <= MODE_OFF;
            set_speed_q   <= '0;
            set_valid_q   <= 1'b0;
            speed_limit_q <= '0;
            acc_active_q  <= 1'b0;
            ramp_cnt_q    <= '0;
            rep_cnt_q     <= '0;
            set_prev_q    <= 1'b0;
            resume_prev_q <= 1'b0;
            inc_prev_q    <= 1'b0;
            dec_prev_q    <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            set_speed_q   <= set_speed_d;
            set_valid_q   <= set_valid_d;
            speed_limit_q <= speed_limit_d;
            acc_active_q  <= acc_active_d;
            ramp_cnt_q    <= ramp_cnt_d;
            rep_cnt_q     <= rep_cnt_d;
            set_prev_q    <= sup.set_btn;
            resume_prev_q <= sup.resume_btn;
            inc_prev_q    <= sup.inc_btn;
            dec_prev_q    <= sup.dec_btn;
        end
    end

    assign sup.mode        = mode_q;
    assign sup.set_speed   = set_speed_q;
    assign sup.set_valid   = set_valid_q;
    assign sup.speed_limit = speed_limit_q;
    assign sup.acc_active  = acc_active_q;

endmodule

// File: tb/tb_acc_supervisor.sv
// tb/tb_acc_supervisor.sv - scoreboard bench for acc_supervisor
module tb_acc_supervisor;

    logic clk;
    logic rstn;
    acc_supervisor_if sup ();

    acc_supervisor #(.OVR_TIMEOUT(16'd10)) dut (
        .clk  (clk),
        .rstn (rstn),
        .sup  (sup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [1:0] mode;
        logic       sv;
        logic [7:0] ss;
        logic [7:0] sl;
        bit         sl_care;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [1:0] m, input logic v,
                            input logic [7:0] s, input logic [7:0] l, input bit lc);
        exp_t e;
        e.tag = tag; e.mode = m; e.sv = v; e.ss = s; e.sl = l; e.sl_care = lc;
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty got=0 exp=1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".mode"},   16'(sup.mode),       16'(e.mode));
            chk({e.tag, ".valid"},  16'(sup.set_valid),  16'(e.sv));
            chk({e.tag, ".set"},    16'(sup.set_speed),  16'(e.ss));
            chk({e.tag, ".active"}, 16'(sup.acc_active), 16'(e.mode == 2'b10));
            if (e.sl_care) chk({e.tag, ".limit"}, 16'(sup.speed_limit), 16'(e.sl));
            else if (e.mode != 2'b10) chk({e.tag, ".limit0"}, 16'(sup.speed_limit), 16'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic tick_chk(input string tag, input logic [1:0] m, input logic v,
                            input logic [7:0] s, input logic [7:0] l, input bit lc);
        push_exp(tag, m, v, s, l, lc);
        tick();
        pop_cmp();
    endtask

    task automatic now_chk(input string tag, input logic [1:0] m, input logic v,
                           input logic [7:0] s, input logic [7:0] l);
        push_exp(tag, m, v, s, l, 1'b1);
        pop_cmp();
    endtask

    initial begin
        rstn = 1'b0;
        sup.acc_on = 0; sup.set_btn = 0; sup.resume_btn = 0;
        sup.inc_btn = 0; sup.dec_btn = 0; sup.brake = 0; sup.car_speed = 8'd0;
        #12;
        now_chk("reset", 2'b00, 0, 0, 0);
        @(negedge clk) rstn = 1'b1;
        tick();

        sup.acc_on = 1; sup.car_speed = 8'd60;
        tick_chk("standby", 2'b01, 0, 0, 0, 1);
        sup.set_btn = 1;
        tick_chk("set60", 2'b10, 1, 60, 60, 1);
        sup.set_btn = 0;
        tick_chk("hold60", 2'b10, 1, 60, 60, 1);

        sup.inc_btn = 1;
        tick_chk("inc_edge", 2'b10, 1, 62, 60, 1);
        run(7);
        tick_chk("inc_rep1", 2'b10, 1, 64, 62, 1);
        run(7);
        tick_chk("inc_rep2", 2'b10, 1, 66, 64, 1);
        sup.inc_btn = 0;
        run(1);
        tick_chk("ramp65", 2'b10, 1, 66, 65, 1);
        run(3);
        tick_chk("ramp66", 2'b10, 1, 66, 66, 1);
        run(8);
        tick_chk("ramp_stop", 2'b10, 1, 66, 66, 1);

        sup.dec_btn = 1;
        tick_chk("dec_drop", 2'b10, 1, 64, 64, 1);
        sup.dec_btn = 0;
        tick();

        sup.car_speed = 8'd118; sup.set_btn = 1;
        tick_chk("recap118", 2'b10, 1, 118, 0, 0);
        sup.set_btn = 0; sup.inc_btn = 1;
        tick_chk("sat_edge", 2'b10, 1, 120, 0, 0);
        run(7);
        tick_chk("sat_rep", 2'b10, 1, 120, 0, 0);
        sup.inc_btn = 0;
        tick();

        sup.car_speed = 8'd30; sup.set_btn = 1;
        tick_chk("recap30", 2'b10, 1, 30, 30, 1);
        sup.set_btn = 0; sup.dec_btn = 1;
        tick_chk("floor_edge", 2'b10, 1, 30, 30, 1);
        run(7);
        tick_chk("floor_rep", 2'b10, 1, 30, 30, 1);
        sup.dec_btn = 0;
        tick();

        sup.car_speed = 8'd60; sup.set_btn = 1;
        tick_chk("recap60", 2'b10, 1, 60, 0, 0);
        sup.set_btn = 0; sup.inc_btn = 1; sup.dec_btn = 1;
        run(10);
        tick_chk("both_btn", 2'b10, 1, 60, 0, 0);
        sup.inc_btn = 0; sup.dec_btn = 0;

        sup.brake = 1;
        tick_chk("brake", 2'b11, 1, 60, 0, 1);
        sup.brake = 0;
        tick_chk("ovr_stay", 2'b11, 1, 60, 0, 1);
        sup.car_speed = 8'd50; sup.resume_btn = 1;
        tick_chk("resume", 2'b10, 1, 60, 50, 1);
        sup.resume_btn = 0;
        run(3);
        tick_chk("reramp", 2'b10, 1, 60, 51, 1);

        sup.car_speed = 8'd80; sup.brake = 1; sup.set_btn = 1;
        tick_chk("brake_over_set", 2'b11, 1, 60, 0, 1);
        sup.brake = 0;
        tick_chk("set_held", 2'b11, 1, 60, 0, 1);
        sup.set_btn = 0;
        tick();
        sup.set_btn = 1;
        tick_chk("ovr_set", 2'b10, 1, 80, 80, 1);
        sup.set_btn = 0; sup.dec_btn = 1;
        tick_chk("dec_same_cycle", 2'b10, 1, 78, 78, 1);
        sup.dec_btn = 0;

        sup.acc_on = 0;
        tick_chk("acc_off", 2'b00, 0, 0, 0, 1);
        sup.acc_on = 1;
        tick_chk("standby2", 2'b01, 0, 0, 0, 1);
        sup.resume_btn = 1;
        tick_chk("resume_novalid", 2'b01, 0, 0, 0, 1);
        sup.resume_btn = 0; sup.car_speed = 8'd25; sup.set_btn = 1;
        tick_chk("set_low", 2'b01, 0, 0, 0, 1);
        sup.set_btn = 0;
        tick();
        sup.car_speed = 8'd121; sup.set_btn = 1;
        tick_chk("set_high", 2'b01, 0, 0, 0, 1);
        sup.set_btn = 0;
        tick();
        sup.car_speed = 8'd120; sup.set_btn = 1;
        tick_chk("set_max", 2'b10, 1, 120, 120, 1);
        sup.set_btn = 0;

        #3 rstn = 1'b0;
        #1 now_chk("async_rst", 2'b00, 0, 0, 0);
        @(negedge clk) rstn = 1'b1;
        tick();
        now_chk("post_rst", 2'b01, 0, 0, 0);

        sup.car_speed = 8'd60; sup.set_btn = 1;
        tick_chk("set_t", 2'b10, 1, 60, 60, 1);
        sup.set_btn = 0; sup.brake = 1;
        tick_chk("brake_t", 2'b11, 1, 60, 0, 1);
`ifdef ACC_SUP_OVR_TIMEOUT_EN
        run(8);
        tick_chk("ovr_last", 2'b11, 1, 60, 0, 1);
        tick_chk("ovr_timeout", 2'b01, 0, 60, 0, 1);
        sup.brake = 0; sup.resume_btn = 1;
        tick_chk("resume_after_to", 2'b01, 0, 60, 0, 1);
`else
        run(20);
        tick_chk("ovr_persist", 2'b11, 1, 60, 0, 1);
        sup.brake = 0; sup.resume_btn = 1;
        tick_chk("resume_late", 2'b10, 1, 60, 60, 1);
`endif
        sup.resume_btn = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
